eth_rx_slot_writer: RTL and testbench
=====================================

// Module: eth_rx_slot_writer
// PURPOSE
//  Ingress stage that writes received Ethernet bytes into port A (16-bit, byte-lane writes) of the RX dual-port buffer.
//  Buffer is a ring of 2^SLOT_BITS slots of 2^(WORD_BITS+1) bytes; one frame per slot.
//  Tracks fill state, per-slot length/error, and drops frames on ring-full.
//  The CPU reads frames via the 64-bit port B and frees them with rel_i.
// PARAMETERS
//  SLOT_BITS  3   log2 number of slots (8 slots)
//  WORD_BITS  10  log2 16-bit words per slot (2048 bytes/slot); SLOT_BITS+WORD_BITS = 13 = buffer port A addr width
// PORTS
//  clk_i        in   1   single clock; buffer port A runs on the same clock
//  rst_ni       in   1   asynchronous active-low reset
//  rx_tdata_i   in   8   stream byte from MAC
//  rx_tvalid_i  in   1   byte valid
//  rx_tready_o  out  1   always 1 out of reset; block never back-pressures
//  rx_tlast_i   in   1   last byte of frame
//  rx_tuser_i   in   1   frame error (sampled on tlast beat only)
//  mem_addr_o   out  13  {slot, word offset}
//  mem_din_o    out  16  {byte,byte}
//  mem_we_o     out  2   byte-lane write enable: 01 = even byte, 10 = odd byte
//  mem_en_o     out  1   port enable, equals |mem_we_o
//  rel_i        in   1   one-cycle pulse: oldest filled slot consumed
//  avail_o      out  SLOT_BITS+1  filled slots, 0..2^SLOT_BITS
//  head_slot_o  out  SLOT_BITS    index of oldest filled slot
//  head_len_o   out  WORD_BITS+2  byte length of oldest frame, 1..2048
//  head_err_o   out  1   oldest frame carried error or was truncated
//  drop_cnt_o   out  16  saturating count of dropped frames
// BEHAVIOUR
//  Reset: rx_tready_o=0; mem_we_o=0, mem_en_o=0, mem_addr_o=0, mem_din_o=0; avail_o=0, head_slot_o=0,
//   head_len_o=0, head_err_o=0, drop_cnt_o=0; wr/rd slot pointers=0; FSM=IDLE. A reset mid-frame abandons the frame; nothing is committed.
//  Beat accepted when rx_tvalid_i & rx_tready_o. Memory outputs are registered; the write appears 1 cycle after the beat.
//   mem_addr_o={wr_ptr, boff[WORD_BITS:1]}; mem_we_o = boff[0] ? 2'b10 : 2'b01; boff = byte offset within the frame.
//  FSM:
//   IDLE: first beat -> if avail_o == 2^SLOT_BITS (full), enter DROP (no write), otherwise write at boff=0 and enter WRITE.
//    A single-beat frame (tlast on the first beat) commits or drops immediately and stays in IDLE.
//   WRITE: write each beat and increment boff. At boff == 2^(WORD_BITS+1) (slot full), suppress further writes,
//    set trunc, and stay in WRITE until tlast.
//   DROP: discard beats until tlast; then drop_cnt++ (saturates at 0xFFFF) and return to IDLE.
//  Commit on the tlast beat in WRITE:
//   - len[wr_ptr] = bytes written, including the tlast byte; capped at 2048.
//   - err[wr_ptr] = rx_tuser_i | trunc.
//   - wr_ptr++ (wraps modulo 2^SLOT_BITS), avail++; then return to IDLE.
//   - A commit is visible on avail_o the cycle after the tlast beat, i.e. the same cycle as the final memory write.
//  Release: rel_i with avail_o > 0 -> rd_ptr++ (wraps), avail--. rel_i with avail_o == 0 is ignored.
//  Simultaneous commit and release: avail_o unchanged; both pointers advance.
//  head_slot_o = rd_ptr; head_len_o / head_err_o are read from the len/err arrays at rd_ptr; all registered.
//  Full check: made only at frame start. A slot freed mid-frame does not rescue a frame already in DROP.
// CONFIGURATION
//  ETH_RX_DROP_ERR_EN defined: a frame with rx_tuser_i=1 on its tlast beat is not committed.
//   wr_ptr and avail_o are unchanged, drop_cnt++, and the slot is reused by the next frame.
//   Truncated frames are still committed with err=1.
//  ETH_RX_DROP_ERR_EN undefined: errored frames are committed with head_err_o=1 and are not counted as drops.
// TESTING
//  1. 5-byte frame 11..55 into an empty ring -> writes at addr 0,0,1,1,2 with we 01,10,01,10,01;
//     avail_o=1, head_len_o=5, head_err_o=0.
//  2. 9 back-to-back frames of 64 bytes, no rel_i -> 8 committed (wr_ptr wraps to 0), 9th frame produces no writes,
//     drop_cnt_o=1. Then 1 rel_i -> avail_o=7, head_slot_o=1.
//  3. 2100-byte frame -> 2048 bytes written, last addr={slot,10'h3FF} with we=10; head_len_o=2048, head_err_o=1.
//  4. rel_i coincident with the tlast beat of a commit at avail_o=3 -> avail_o stays 3, head_slot_o advances by 1.
//  5. 64-byte frame with tuser=1 on tlast -> macro on: avail_o unchanged, drop_cnt_o=1;
//     macro off: avail_o=1, head_err_o=1.
//  6. rst_ni low at byte 30 of a frame, then a 10-byte frame -> avail_o=1, head_slot_o=0, head_len_o=10;
//     rel_i at avail_o=0 has no effect.

Source files
------------

// File: rtl/eth_rx_slot_writer.sv
// Ingress stage: writes MAC RX bytes into a slot ring of the RX dual-port buffer (port A).
// Optional build macro ETH_RX_DROP_ERR_EN: errored frames are dropped instead of committed.
module eth_rx_slot_writer #(
    parameter int unsigned SLOT_BITS = 3,
    parameter int unsigned WORD_BITS = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [7:0]                 rx_tdata_i,
    input  logic                       rx_tvalid_i,
    output logic                       rx_tready_o,
    input  logic                       rx_tlast_i,
    input  logic                       rx_tuser_i,
    output logic [SLOT_BITS+WORD_BITS-1:0] mem_addr_o,
    output logic [15:0]                mem_din_o,
    output logic [1:0]                 mem_we_o,
    output logic                       mem_en_o,
    input  logic                       rel_i,
    output logic [SLOT_BITS:0]         avail_o,
    output logic [SLOT_BITS-1:0]       head_slot_o,
    output logic [WORD_BITS+1:0]       head_len_o,
    output logic                       head_err_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned NSLOT = 1 << SLOT_BITS;
    localparam int unsigned AW    = SLOT_BITS + WORD_BITS;
    localparam int unsigned LW    = WORD_BITS + 2;
    localparam int unsigned CW    = SLOT_BITS + 1;
    localparam logic [LW-1:0] SLOT_BYTES = LW'(1 << (WORD_BITS + 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LW-1:0]         boff_q, boff_d;
    logic                  trunc_q, trunc_d;
    logic [SLOT_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [SLOT_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         avail_q, avail_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic [LW-1:0]         len_q [NSLOT];
    logic                  err_q [NSLOT];
    logic [LW-1:0]         head_len_q, head_len_d;
    logic                  head_err_q, head_err_d;
    logic                  rdy_q;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [15:0]           mem_din_q, mem_din_d;
    logic [1:0]            mem_we_q, mem_we_d;
    logic                  mem_en_q, mem_en_d;

    logic                  beat;
    logic                  wr_beat;
    logic                  commit;
    logic                  do_commit;
    logic                  drop_inc;
    logic                  rel_ok;
    logic [LW-1:0]         commit_len;
    logic                  commit_err;

    // State register, pointers, per-slot length/error table and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            boff_q     <= '0;
            trunc_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            avail_q    <= '0;
            drop_cnt_q <= '0;
            head_len_q <= '0;
            head_err_q <= 1'b0;
            rdy_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= '0;
            mem_en_q   <= 1'b0;
            for (int i = 0; i < int'(NSLOT); i++) begin
                len_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            boff_q     <= boff_d;
            trunc_q    <= trunc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            avail_q    <= avail_d;
            drop_cnt_q <= drop_cnt_d;
            head_len_q <= head_len_d;
            head_err_q <= head_err_d;
            rdy_q      <= 1'b1;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            mem_en_q   <= mem_en_d;
            if (do_commit) begin
                len_q[wr_ptr_q] <= commit_len;
                err_q[wr_ptr_q] <= commit_err;
            end
        end
    end

    // Frame FSM, memory write generation and ring bookkeeping
    always_comb begin
        state_d    = state_q;
        boff_d     = boff_q;
        trunc_d    = trunc_q;
        wr_beat    = 1'b0;
        commit     = 1'b0;
        drop_inc   = 1'b0;
        commit_len = '0;
        commit_err = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = 2'b00;
        beat       = rx_tvalid_i & rdy_q;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (avail_q == CW'(NSLOT)) begin
                        if (rx_tlast_i) begin
                            drop_inc = 1'b1;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        wr_beat = 1'b1;
                        if (rx_tlast_i) begin
                            commit     = 1'b1;
                            commit_len = LW'(1);
                            commit_err = rx_tuser_i;
                        end else begin
                            state_d = WRITE;
                            boff_d  = LW'(1);
                            trunc_d = 1'b0;
                        end
                    end
                end
            end
            WRITE: begin
                if (beat) begin
                    // Once the slot is full, keep swallowing bytes but flag the frame as truncated
                    if (boff_q == SLOT_BYTES) begin
                        trunc_d = 1'b1;
                    end else begin
                        wr_beat = 1'b1;
                        boff_d  = boff_q + LW'(1);
                    end
                    if (rx_tlast_i) begin
                        commit     = 1'b1;
                        commit_len = (boff_q == SLOT_BYTES) ? SLOT_BYTES : boff_q + LW'(1);
                        commit_err = rx_tuser_i | trunc_q | (boff_q == SLOT_BYTES);
                        state_d    = IDLE;
                        boff_d     = '0;
                        trunc_d    = 1'b0;
                    end
                end
            end
            DROP: begin
                if (beat && rx_tlast_i) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                boff_d  = '0;
                trunc_d = 1'b0;
            end
        endcase

        if (wr_beat) begin
            mem_we_d   = boff_q[0] ? 2'b10 : 2'b01;
            mem_addr_d = {wr_ptr_q, boff_q[WORD_BITS:1]};
            mem_din_d  = {rx_tdata_i, rx_tdata_i};
        end
        mem_en_d = |mem_we_d;

`ifdef ETH_RX_DROP_ERR_EN
        // Frames flagged bad by the MAC are discarded; the slot is reused by the next frame
        do_commit = commit & ~rx_tuser_i;
        if (commit && rx_tuser_i) begin
            drop_inc = 1'b1;
        end
`else
        do_commit = commit;
`endif

        rel_ok   = rel_i & (avail_q != '0);
        wr_ptr_d = do_commit ? wr_ptr_q + SLOT_BITS'(1) : wr_ptr_q;
        rd_ptr_d = rel_ok ? rd_ptr_q + SLOT_BITS'(1) : rd_ptr_q;

        case ({do_commit, rel_ok})
            2'b10:   avail_d = avail_q + CW'(1);
            2'b01:   avail_d = avail_q - CW'(1);
            default: avail_d = avail_q;
        endcase

        drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

        // Forward a commit into the head slot so head info lines up with avail_o
        if (do_commit && (wr_ptr_q == rd_ptr_d)) begin
            head_len_d = commit_len;
            head_err_d = commit_err;
        end else begin
            head_len_d = len_q[rd_ptr_d];
            head_err_d = err_q[rd_ptr_d];
        end
    end

    assign rx_tready_o = rdy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_din_o   = mem_din_q;
    assign mem_we_o    = mem_we_q;
    assign mem_en_o    = mem_en_q;
    assign avail_o     = avail_q;
    assign head_slot_o = rd_ptr_q;
    assign head_len_o  = head_len_q;
    assign head_err_o  = head_err_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_slot_writer.sv
// Directed bench for eth_rx_slot_writer: ring fill, wrap, drop, truncation, release and reset cases.
module tb_eth_rx_slot_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic        rx_tlast;
    logic        rx_tuser;
    logic [12:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic        mem_en;
    logic        rel;
    logic [3:0]  avail;
    logic [2:0]  head_slot;
    logic [11:0] head_len;
    logic        head_err;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Write log filled by the monitor
    int          wr_cnt = 0;
    logic [12:0] log_addr  [8192];
    logic [15:0] log_din   [8192];
    logic [1:0]  log_we    [8192];
    logic        log_en    [8192];
    logic [3:0]  log_avail [8192];

    always #5 clk = ~clk;

    eth_rx_slot_writer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_tdata_i  (rx_tdata),
        .rx_tvalid_i (rx_tvalid),
        .rx_tready_o (rx_tready),
        .rx_tlast_i  (rx_tlast),
        .rx_tuser_i  (rx_tuser),
        .mem_addr_o  (mem_addr),
        .mem_din_o   (mem_din),
        .mem_we_o    (mem_we),
        .mem_en_o    (mem_en),
        .rel_i       (rel),
        .avail_o     (avail),
        .head_slot_o (head_slot),
        .head_len_o  (head_len),
        .head_err_o  (head_err),
        .drop_cnt_o  (drop_cnt)
    );

    always @(negedge clk) begin
        if (mem_we != 2'b00) begin
            if (wr_cnt < 8192) begin
                log_addr[wr_cnt]  = mem_addr;
                log_din[wr_cnt]   = mem_din;
                log_we[wr_cnt]    = mem_we;
                log_en[wr_cnt]    = mem_en;
                log_avail[wr_cnt] = avail;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; rel = 1'b0; rx_tdata = 8'h00;
        idle(2);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic send_frame(input int n, input logic [7:0] d0, input logic [7:0] step,
                              input logic tuser, input logic rel_last);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rx_tvalid = 1'b1;
            rx_tdata  = d0 + 8'(k) * step;
            rx_tlast  = (k == n - 1);
            rx_tuser  = (k == n - 1) ? tuser : 1'b0;
            rel       = (k == n - 1) ? rel_last : 1'b0;
        end
        @(negedge clk);
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; rel = 1'b0;
        idle(2);
    endtask

    task automatic pulse_rel();
        @(negedge clk); rel = 1'b1;
        @(negedge clk); rel = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; rel = 1'b0; rx_tdata = 8'h00;
        idle(2);
        checks++;
        if ({rx_tready, mem_we, mem_en, mem_addr, mem_din} !== 33'd0) begin
            errors++; $display("FAIL reset_mem: got tready=%b we=%b en=%b addr=%h din=%h, want all 0",
                               rx_tready, mem_we, mem_en, mem_addr, mem_din);
        end
        checks++;
        if ({avail, head_slot, head_len, head_err, drop_cnt} !== 36'd0) begin
            errors++; $display("FAIL reset_status: got avail=%0d slot=%0d len=%0d err=%b drop=%0d, want all 0",
                               avail, head_slot, head_len, head_err, drop_cnt);
        end
        rst_n = 1'b1;
        idle(3);
        checks++;
        if (rx_tready !== 1'b1) begin
            errors++; $display("FAIL reset_tready: got %b, want 1", rx_tready);
        end
    endtask

    task automatic test_first_frame();
        int base;
        logic [7:0] b;
        apply_reset();
        base = wr_cnt;
        send_frame(5, 8'd11, 8'd11, 1'b0, 1'b0);
        checks++;
        if (wr_cnt - base != 5) begin
            errors++; $display("FAIL t1_write_count: got %0d, want 5", wr_cnt - base);
        end
        for (int k = 0; k < 5; k++) begin
            b = 8'(11 * (k + 1));
            checks++;
            if ({log_addr[base+k], log_we[base+k], log_din[base+k], log_en[base+k]} !==
                {13'(k / 2), ((k % 2) == 1) ? 2'b10 : 2'b01, b, b, 1'b1}) begin
                errors++; $display("FAIL t1_write%0d: got addr=%h we=%b din=%h en=%b, want addr=%h we=%b din=%h en=1",
                                   k, log_addr[base+k], log_we[base+k], log_din[base+k], log_en[base+k],
                                   13'(k / 2), ((k % 2) == 1) ? 2'b10 : 2'b01, {b, b});
            end
        end
        checks++;
        if (log_avail[base+4] !== 4'd1 || log_avail[base+3] !== 4'd0) begin
            errors++; $display("FAIL t1_commit_timing: got avail %0d/%0d at writes 3/4, want 0/1",
                               log_avail[base+3], log_avail[base+4]);
        end
        checks++;
        if ({avail, head_slot, head_len, head_err} !== {4'd1, 3'd0, 12'd5, 1'b0}) begin
            errors++; $display("FAIL t1_head: got avail=%0d slot=%0d len=%0d err=%b, want 1 0 5 0",
                               avail, head_slot, head_len, head_err);
        end
    endtask

    task automatic test_single_beat();
        int base;
        apply_reset();
        base = wr_cnt;
        send_frame(1, 8'hA5, 8'd0, 1'b0, 1'b0);
        checks++;
        if (wr_cnt - base != 1 || log_addr[base] !== 13'd0 || log_we[base] !== 2'b01 || log_din[base] !== 16'hA5A5) begin
            errors++; $display("FAIL single_write: got n=%0d addr=%h we=%b din=%h, want 1 0 01 a5a5",
                               wr_cnt - base, log_addr[base], log_we[base], log_din[base]);
        end
        checks++;
        if ({avail, head_len, head_err} !== {4'd1, 12'd1, 1'b0}) begin
            errors++; $display("FAIL single_head: got avail=%0d len=%0d err=%b, want 1 1 0", avail, head_len, head_err);
        end
    endtask

    task automatic test_ring_full();
        int base;
        apply_reset();
        base = wr_cnt;
        for (int f = 0; f < 8; f++) send_frame(64, 8'(f * 16), 8'd1, 1'b0, 1'b0);
        checks++;
        if (wr_cnt - base != 512 || log_addr[base + 7*64] !== 13'h1C00) begin
            errors++; $display("FAIL t2_fill: got n=%0d slot7_addr=%h, want 512 1c00", wr_cnt - base, log_addr[base + 7*64]);
        end
        send_frame(64, 8'h80, 8'd1, 1'b0, 1'b0);
        checks++;
        if (wr_cnt - base != 512) begin
            errors++; $display("FAIL t2_drop_nowrite: got %0d writes, want 512", wr_cnt - base);
        end
        checks++;
        if ({avail, drop_cnt, head_slot, head_len} !== {4'd8, 16'd1, 3'd0, 12'd64}) begin
            errors++; $display("FAIL t2_full: got avail=%0d drop=%0d slot=%0d len=%0d, want 8 1 0 64",
                               avail, drop_cnt, head_slot, head_len);
        end
        pulse_rel();
        checks++;
        if ({avail, head_slot, head_len} !== {4'd7, 3'd1, 12'd64}) begin
            errors++; $display("FAIL t2_release: got avail=%0d slot=%0d len=%0d, want 7 1 64", avail, head_slot, head_len);
        end
        base = wr_cnt;
        send_frame(3, 8'h01, 8'd1, 1'b0, 1'b0);
        checks++;
        if (wr_cnt - base != 3 || log_addr[base] !== 13'h0000 || avail !== 4'd8) begin
            errors++; $display("FAIL t2_wrap: got n=%0d addr=%h avail=%0d, want 3 0000 8", wr_cnt - base, log_addr[base], avail);
        end
    endtask

    task automatic test_truncate();
        int base;
        apply_reset();
        base = wr_cnt;
        send_frame(2100, 8'h00, 8'd1, 1'b0, 1'b0);
        checks++;
        if (wr_cnt - base != 2048) begin
            errors++; $display("FAIL t3_count: got %0d writes, want 2048", wr_cnt - base);
        end
        checks++;
        if ({log_addr[base+2047], log_we[base+2047], log_din[base+2047]} !== {13'h03FF, 2'b10, 16'hFFFF}) begin
            errors++; $display("FAIL t3_last_write: got addr=%h we=%b din=%h, want 03ff 10 ffff",
                               log_addr[base+2047], log_we[base+2047], log_din[base+2047]);
        end
        checks++;
        if ({avail, head_len, head_err} !== {4'd1, 12'd2048, 1'b1}) begin
            errors++; $display("FAIL t3_head: got avail=%0d len=%0d err=%b, want 1 2048 1", avail, head_len, head_err);
        end
        base = wr_cnt;
        send_frame(2048, 8'h00, 8'd1, 1'b0, 1'b0);
        pulse_rel();
        checks++;
        if ({wr_cnt - base == 2048, log_addr[base+2047], head_slot, head_len, head_err} !==
            {1'b1, 13'h07FF, 3'd1, 12'd2048, 1'b0}) begin
            errors++; $display("FAIL t3_exact: got n=%0d addr=%h slot=%0d len=%0d err=%b, want 2048 07ff 1 2048 0",
                               wr_cnt - base, log_addr[base+2047], head_slot, head_len, head_err);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_frame(4, 8'h10, 8'd1, 1'b0, 1'b0);
        send_frame(5, 8'h20, 8'd1, 1'b0, 1'b0);
        send_frame(6, 8'h30, 8'd1, 1'b0, 1'b0);
        checks++;
        if ({avail, head_slot, head_len} !== {4'd3, 3'd0, 12'd4}) begin
            errors++; $display("FAIL t4_pre: got avail=%0d slot=%0d len=%0d, want 3 0 4", avail, head_slot, head_len);
        end
        send_frame(7, 8'h40, 8'd1, 1'b0, 1'b1);
        checks++;
        if ({avail, head_slot, head_len} !== {4'd3, 3'd1, 12'd5}) begin
            errors++; $display("FAIL t4_coincident: got avail=%0d slot=%0d len=%0d, want 3 1 5", avail, head_slot, head_len);
        end
    endtask

    task automatic test_err_frame();
        int base;
        apply_reset();
        send_frame(64, 8'h00, 8'd1, 1'b1, 1'b0);
`ifdef ETH_RX_DROP_ERR_EN
        checks++;
        if ({avail, drop_cnt} !== {4'd0, 16'd1}) begin
            errors++; $display("FAIL t5_err_drop: got avail=%0d drop=%0d, want 0 1", avail, drop_cnt);
        end
        base = wr_cnt;
        send_frame(10, 8'h00, 8'd1, 1'b0, 1'b0);
        checks++;
        if ({log_addr[base], avail, head_len, head_err} !== {13'd0, 4'd1, 12'd10, 1'b0}) begin
            errors++; $display("FAIL t5_reuse: got addr=%h avail=%0d len=%0d err=%b, want 0 1 10 0",
                               log_addr[base], avail, head_len, head_err);
        end
`else
        checks++;
        if ({avail, head_len, head_err, drop_cnt} !== {4'd1, 12'd64, 1'b1, 16'd0}) begin
            errors++; $display("FAIL t5_err_commit: got avail=%0d len=%0d err=%b drop=%0d, want 1 64 1 0",
                               avail, head_len, head_err, drop_cnt);
        end
        base = wr_cnt;
        send_frame(10, 8'h00, 8'd1, 1'b0, 1'b0);
        checks++;
        if ({log_addr[base], avail} !== {13'h0400, 4'd2}) begin
            errors++; $display("FAIL t5_next: got addr=%h avail=%0d, want 0400 2", log_addr[base], avail);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        int base;
        apply_reset();
        for (int k = 0; k < 29; k++) begin
            @(negedge clk);
            rx_tvalid = 1'b1; rx_tdata = 8'(k); rx_tlast = 1'b0; rx_tuser = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0; rx_tvalid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        pulse_rel();
        checks++;
        if ({avail, head_slot, drop_cnt} !== {4'd0, 3'd0, 16'd0}) begin
            errors++; $display("FAIL t6_rel_empty: got avail=%0d slot=%0d drop=%0d, want 0 0 0", avail, head_slot, drop_cnt);
        end
        base = wr_cnt;
        send_frame(10, 8'h50, 8'd1, 1'b0, 1'b0);
        checks++;
        if ({log_addr[base], avail, head_slot, head_len, head_err} !== {13'd0, 4'd1, 3'd0, 12'd10, 1'b0}) begin
            errors++; $display("FAIL t6_after_reset: got addr=%h avail=%0d slot=%0d len=%0d err=%b, want 0 1 0 10 0",
                               log_addr[base], avail, head_slot, head_len, head_err);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_single_beat();
        test_ring_full();
        test_truncate();
        test_back_to_back();
        test_err_frame();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
